bus_rr_sched: RTL and testbench

BUS_RR_SCHED -- requirements
Module: bus_rr_sched

---
 rtl/bus_rr_sched.sv | 148 ++++++++++++++
 tb/tb_bus_rr_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_sched.sv
// Round-robin scheduler moving one packet at a time from driver FIFOs to
// destination FIFOs: arbitrate, pop, decode destination ID, push (or drop).
module bus_rr_sched #(
  parameter int unsigned width     = 16,
  parameter int unsigned drvs      = 8,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [drvs-1:0]           pndng,
  input  logic [drvs*width-1:0]     D_pop,
  output logic [drvs-1:0]           pop,
  output logic [drvs-1:0]           push,
  output logic [width-1:0]          D_push,
  output logic                      busy,
  output logic [$clog2(drvs)-1:0]   grant_id,
  output logic [15:0]               drop_cnt
);

  localparam int unsigned idx_w = $clog2(drvs);
  localparam int unsigned id_w  = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_POP    = 2'd1;
  localparam logic [1:0] ST_DECODE = 2'd2;
  localparam logic [1:0] ST_PUSH   = 2'd3;

  logic [1:0]       state_q,   state_d;
  logic [idx_w-1:0] rr_ptr_q,  rr_ptr_d;
  logic [idx_w-1:0] grant_q,   grant_d;
  logic [width-1:0] data_q,    data_d;
  logic [drvs-1:0]  push_q,    push_d;
  logic [width-1:0] d_push_q,  d_push_d;
  logic [15:0]      drop_q,    drop_d;
  logic             busy_q,    busy_d;

  logic             req_found;
  logic [idx_w-1:0] req_idx;
  logic [31:0]      cand;
  logic [id_w-1:0]  pkt_id;
  logic [drvs-1:0]  grant_oh;
  logic [drvs-1:0]  dest_oh;
  logic [idx_w-1:0] next_ptr;
  logic             id_valid;

  assign pkt_id   = data_q[width-1 -: id_w];
  assign grant_oh = drvs'(1) << grant_q;
  assign dest_oh  = drvs'(1) << pkt_id[idx_w-1:0];
  assign id_valid = (pkt_id < id_w'(drvs)) && (pkt_id != id_w'(grant_q));
  assign next_ptr = (grant_q == idx_w'(drvs - 1)) ? '0 : grant_q + idx_w'(1);

  // Circular search for the first pending driver at or after rr_ptr.
  always_comb begin
    req_found = 1'b0;
    req_idx   = rr_ptr_q;
    cand      = '0;
    for (int unsigned k = 0; k < drvs; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= drvs) cand = cand - drvs;
      if (!req_found && pndng[cand[idx_w-1:0]]) begin
        req_found = 1'b1;
        req_idx   = cand[idx_w-1:0];
      end
    end
  end

  // Next-state and output logic; pop follows pndng live so a withdrawn
  // request in POP never produces a strobe.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    data_d   = data_q;
    push_d   = '0;
    d_push_d = d_push_q;
    drop_d   = drop_q;
    pop      = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_found) begin
          grant_d = req_idx;
          state_d = ST_POP;
        end
      end
      ST_POP: begin
        if (pndng[grant_q]) begin
          pop     = grant_oh;
          data_d  = D_pop[32'(grant_q)*width +: width];
          state_d = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (pkt_id == broadcast) begin
          push_d   = ~grant_oh;
          d_push_d = data_q;
          state_d  = ST_PUSH;
        end else if (id_valid) begin
          push_d   = dest_oh;
          d_push_d = data_q;
          state_d  = ST_PUSH;
        end else begin
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          rr_ptr_d = next_ptr;
          state_d  = ST_IDLE;
        end
      end
      ST_PUSH: begin
        rr_ptr_d = next_ptr;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      push_q   <= '0;
      d_push_q <= '0;
      drop_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      push_q   <= push_d;
      d_push_q <= d_push_d;
      drop_q   <= drop_d;
      busy_q   <= busy_d;
    end
  end

  assign push     = push_q;
  assign D_push   = d_push_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_bus_rr_sched.sv
// Directed bench for bus_rr_sched: table of single-packet transfers plus
// hand-written sequences for abort, reset-in-flight and round-robin order.
module tb_bus_rr_sched;

  localparam int unsigned W = 16;
  localparam int unsigned N = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   pndng;
  logic [N*W-1:0] D_pop;
  logic [N-1:0]   pop;
  logic [N-1:0]   push;
  logic [W-1:0]   D_push;
  logic           busy;
  logic [2:0]     grant_id;
  logic [15:0]    drop_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  pn;
    int          slot;
    logic [15:0] pkt;
    logic [2:0]  g;
    logic [7:0]  e_pop;
    logic [7:0]  e_push;
    logic [15:0] e_dp;
    logic [15:0] e_drop;
  } vec_t;

  vec_t vecs[11];

  bus_rr_sched #(.width(W), .drvs(N), .broadcast(8'hFF)) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .busy     (busy),
    .grant_id (grant_id),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Packet in the chosen slot, distinct out-of-range filler everywhere else.
  task automatic load_slot(input int slot, input logic [15:0] pkt);
    for (int j = 0; j < int'(N); j++)
      D_pop[j*W +: W] = (j == slot) ? pkt : (16'hEE00 | 16'(j));
  endtask

  // One transfer starting from IDLE at a falling edge with inputs already set.
  task automatic do_txn(input logic [2:0] g, input logic [7:0] e_pop, input logic [7:0] e_push,
                        input logic [15:0] e_dp, input logic [15:0] e_drop, input bit noise);
    @(posedge clk); @(negedge clk);
    chk("busy_in_pop", 32'(busy), 32'd1);
    chk("grant_id", 32'(grant_id), 32'(g));
    chk("pop", 32'(pop), 32'(e_pop));
    chk("push_in_pop", 32'(push), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("pop_in_decode", 32'(pop), 32'd0);
    chk("push_in_decode", 32'(push), 32'd0);
    if (noise) begin
      pndng = 8'hFF;
      D_pop = ~D_pop;
    end
    @(posedge clk); @(negedge clk);
    chk("push", 32'(push), 32'(e_push));
    chk("d_push", 32'(D_push), 32'(e_dp));
    chk("drop_cnt", 32'(drop_cnt), 32'(e_drop));
    chk("pop_after_pop", 32'(pop), 32'd0);
    if (e_push != 8'h00) begin
      chk("busy_in_push", 32'(busy), 32'd1);
      @(posedge clk); @(negedge clk);
      chk("push_one_cycle", 32'(push), 32'd0);
      chk("d_push_hold", 32'(D_push), 32'(e_dp));
    end
    chk("busy_idle", 32'(busy), 32'd0);
    if (noise) pndng = '0;
  endtask

  initial begin
    logic [7:0]  oh_g;
    logic [7:0]  oh_d;
    logic [2:0]  gg;
    logic [2:0]  dd;

    vecs[0]  = '{8'h04, 2, 16'h05AB, 3'd2, 8'h04, 8'h20, 16'h05AB, 16'd0};
    vecs[1]  = '{8'h08, 3, 16'hFF11, 3'd3, 8'h08, 8'hF7, 16'hFF11, 16'd0};
    vecs[2]  = '{8'h03, 0, 16'h0712, 3'd0, 8'h01, 8'h80, 16'h0712, 16'd0};
    vecs[3]  = '{8'h02, 1, 16'h0133, 3'd1, 8'h02, 8'h00, 16'h0712, 16'd1};
    vecs[4]  = '{8'h02, 1, 16'h0944, 3'd1, 8'h02, 8'h00, 16'h0712, 16'd2};
    vecs[5]  = '{8'h06, 2, 16'h0055, 3'd2, 8'h04, 8'h01, 16'h0055, 16'd2};
    vecs[6]  = '{8'h81, 7, 16'h0266, 3'd7, 8'h80, 8'h04, 16'h0266, 16'd2};
    vecs[7]  = '{8'h81, 0, 16'hFF77, 3'd0, 8'h01, 8'hFE, 16'hFF77, 16'd2};
    vecs[8]  = '{8'h80, 7, 16'hFF88, 3'd7, 8'h80, 8'h7F, 16'hFF88, 16'd2};
    vecs[9]  = '{8'h10, 4, 16'h08AA, 3'd4, 8'h10, 8'h00, 16'hFF88, 16'd3};
    vecs[10] = '{8'h30, 5, 16'h0799, 3'd5, 8'h20, 8'h80, 16'h0799, 16'd3};

    reset = 1'b0;
    pndng = '0;
    D_pop = '0;
    #1;
    chk("rst_pop", 32'(pop), 32'd0);
    chk("rst_push", 32'(push), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_d_push", 32'(D_push), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      pndng = vecs[i].pn;
      load_slot(vecs[i].slot, vecs[i].pkt);
      do_txn(vecs[i].g, vecs[i].e_pop, vecs[i].e_push, vecs[i].e_dp, vecs[i].e_drop, 1'b1);
    end

    // Reset while in DECODE: everything clears at once, the packet never pushes.
    pndng = 8'h08;
    load_slot(3, 16'h0011);
    @(posedge clk); @(negedge clk);
    chk("rd_grant", 32'(grant_id), 32'd3);
    chk("rd_pop", 32'(pop), 32'h08);
    @(posedge clk); @(negedge clk);
    chk("rd_busy_decode", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("rd_busy", 32'(busy), 32'd0);
    chk("rd_pop0", 32'(pop), 32'd0);
    chk("rd_push0", 32'(push), 32'd0);
    chk("rd_grant0", 32'(grant_id), 32'd0);
    chk("rd_d_push0", 32'(D_push), 32'd0);
    chk("rd_drop0", 32'(drop_cnt), 32'd0);
    pndng = 8'h88;
    load_slot(3, 16'h0520);
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rd_push_held", 32'(push), 32'd0);
    chk("rd_busy_held", 32'(busy), 32'd0);
    reset = 1'b1;
    do_txn(3'd3, 8'h08, 8'h20, 16'h0520, 16'd0, 1'b0);
    pndng = '0;

    // Request withdrawn during POP: no pop, back to IDLE, pointer unchanged.
    pndng = 8'h20;
    load_slot(5, 16'h0101);
    @(posedge clk); @(negedge clk);
    chk("ab_grant", 32'(grant_id), 32'd5);
    chk("ab_busy", 32'(busy), 32'd1);
    pndng = 8'h00;
    #1;
    chk("ab_pop", 32'(pop), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("ab_busy_idle", 32'(busy), 32'd0);
    chk("ab_pop_idle", 32'(pop), 32'd0);
    chk("ab_push", 32'(push), 32'd0);
    chk("ab_d_push", 32'(D_push), 32'h0520);
    pndng = 8'h60;
    do_txn(3'd5, 8'h20, 8'h02, 16'h0101, 16'd0, 1'b0);
    pndng = '0;

    // All drivers pending continuously: grants rotate 0..7 then wrap to 0.
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    pndng = 8'hFF;
    for (int j = 0; j < int'(N); j++)
      D_pop[j*W +: W] = {8'((j + 1) % int'(N)), 8'(j)};
    for (int k = 0; k < 9; k++) begin
      gg   = 3'(k % int'(N));
      dd   = 3'((k + 1) % int'(N));
      oh_g = 8'h01 << gg;
      oh_d = 8'h01 << dd;
      do_txn(gg, oh_g, oh_d, {5'd0, dd, 5'd0, gg}, 16'd0, 1'b0);
    end
    pndng = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
